seq_detector_param: RTL and testbench

- Parametrised serial sequence detector. Successor to the fixed 3-state x/z detector.
- Compares a serial bit stream on x against a runtime-loadable PAT_W-bit pattern, with selectable overlapping or non-overlapping detection.
- Pulses z on every detection and keeps a saturating match count.
- Used as the generic front-end pattern matcher for serial control streams.

---
 rtl/seq_det_pkg.sv | 18 +
 rtl/sat_counter.sv | 35 +++
 rtl/seq_detector_param.sv | 121 ++++++++++++
 tb/tb_seq_detector_param.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and types for the parametrised sequence detector.
//   SEQ_DET_PAT_W     default pattern length
//   SEQ_DET_PAT_RESET default pattern loaded at reset
//   SEQ_DET_CNT_W     default width of the match counter
//   fill_state_e      FSM view of the history fill level (filling / armed)
package seq_det_pkg;

    localparam int unsigned                  SEQ_DET_PAT_W     = 4;
    localparam logic [SEQ_DET_PAT_W-1:0]     SEQ_DET_PAT_RESET = 4'b1101;
    localparam int unsigned                  SEQ_DET_CNT_W     = 8;

    // StArmed means the next valid bit can complete a match.
    typedef enum logic {
        StFilling = 1'b0,
        StArmed   = 1'b1
    } fill_state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that saturates at all-ones.
// Ports:
//   i_clk    clock, rising edge
//   i_reset  asynchronous active-high reset, clears the count
//   i_clr    synchronous clear (wins over i_inc)
//   i_inc    increment request; ignored once the count is all-ones
//   o_count  current count
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = &r_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: serial sequence detector against a runtime-loadable pattern.
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   x, x_valid   serial data bit and its qualifier
//   pattern      new pattern value (MSB = oldest bit), captured when pat_load is high
//   pat_load     synchronous pattern load; clears history, fill and match count
//   overlap_en   1 = overlapping detection, 0 = non-overlapping
//   z            detection pulse
//   match_count  saturating count of detections
//   armed        registered: next valid bit can complete a match
// Build option: define SEQ_DET_MEALY_EN to drive z combinationally from the hit term
// (zero latency). Default build registers z (one cycle after the completing bit).
import seq_det_pkg::*;

module seq_detector_param #(
    parameter int unsigned      PAT_W     = SEQ_DET_PAT_W,
    parameter logic [PAT_W-1:0] PAT_RESET = PAT_W'(SEQ_DET_PAT_RESET),
    parameter int unsigned      CNT_W     = SEQ_DET_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic [PAT_W-1:0] pattern,
    input  logic             pat_load,
    input  logic             overlap_en,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    localparam int unsigned       FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    // Only the newest PAT_W-1 bits are stored: the oldest bit of a window is always
    // the one shifted out on the completing bit, so it is never compared.
    logic [PAT_W-1:0]  r_pat;
    logic [PAT_W-2:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    fill_state_e       r_state;

    logic [PAT_W-1:0]  w_pat_d;
    logic [PAT_W-2:0]  w_hist_d;
    logic [FILL_W-1:0] w_fill_d;
    fill_state_e       w_state_d;
    logic [PAT_W-1:0]  w_window;
    logic              w_hit;

    // Window that the incoming bit would complete.
    assign w_window = {r_hist, x};
    assign w_hit    = x_valid & ~pat_load & (r_state == StArmed) & (w_window == r_pat);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pat   <= PAT_RESET;
            r_hist  <= '0;
            r_fill  <= '0;
            r_state <= StFilling;
        end else begin
            r_pat   <= w_pat_d;
            r_hist  <= w_hist_d;
            r_fill  <= w_fill_d;
            r_state <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_pat_d  = r_pat;
        w_hist_d = r_hist;
        w_fill_d = r_fill;

        if (pat_load) begin
            // Load wins over a simultaneous valid bit, which is dropped.
            w_pat_d  = pattern;
            w_hist_d = '0;
            w_fill_d = '0;
        end else if (x_valid) begin
            w_hist_d = w_window[PAT_W-2:0];
            if (w_hit && !overlap_en) begin
                // Non-overlapping: none of the matched window may be reused.
                w_fill_d = '0;
            end else if (r_fill != FILL_MAX) begin
                w_fill_d = r_fill + 1'b1;
            end
        end

        w_state_d = (w_fill_d == FILL_MAX) ? StArmed : StFilling;
    end

    assign armed = (r_state == StArmed);

`ifdef SEQ_DET_MEALY_EN
    assign z = w_hit;
`else
    logic r_z;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_z <= 1'b0;
        end else begin
            r_z <= w_hit;
        end
    end

    assign z = r_z;
`endif

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_match_cnt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clr   (pat_load),
        .i_inc   (w_hit),
        .o_count (match_count)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: table-driven directed scenarios plus randomized stimulus
// against a queue-based reference model. dut_a uses an 8-bit counter, dut_b a
// 2-bit counter to exercise saturation; both share all inputs.
`timescale 1ns/1ps

module tb_seq_detector_param;

    localparam int unsigned PW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          x;
    logic          x_valid;
    logic [PW-1:0] pattern;
    logic          pat_load;
    logic          overlap_en;

    logic          z_a, armed_a, z_b, armed_b;
    logic [7:0]    cnt_a;
    logic [1:0]    cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_detector_param #(
        .PAT_W     (PW),
        .PAT_RESET (4'b1101),
        .CNT_W     (8)
    ) dut_a (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .x_valid     (x_valid),
        .pattern     (pattern),
        .pat_load    (pat_load),
        .overlap_en  (overlap_en),
        .z           (z_a),
        .match_count (cnt_a),
        .armed       (armed_a)
    );

    seq_detector_param #(
        .PAT_W     (PW),
        .PAT_RESET (4'b1101),
        .CNT_W     (2)
    ) dut_b (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .x_valid     (x_valid),
        .pattern     (pattern),
        .pat_load    (pat_load),
        .overlap_en  (overlap_en),
        .z           (z_b),
        .match_count (cnt_b),
        .armed       (armed_b)
    );

    typedef struct {
        bit            rst;   // pulse reset before applying this row
        bit            xb;
        bit            vb;
        bit            lb;
        logic [PW-1:0] pat;
        bit            ov;
        bit            eh;    // this bit completes a match
        int            ec;    // expected match_count after the edge
        bit            ea;    // expected armed after the edge
    } vec_t;

    vec_t tbl[$];

    // Reference model: the valid bits seen since the last clear, newest at the back.
    bit            mq[$];
    logic [PW-1:0] mpat;
    int            mcnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    function automatic vec_t mk(input bit r, input bit xb, input bit vb, input bit lb,
                                input logic [PW-1:0] pat, input bit ov, input bit eh,
                                input int ec, input bit ea);
        vec_t v;
        v.rst = r; v.xb = xb; v.vb = vb; v.lb = lb; v.pat = pat;
        v.ov = ov; v.eh = eh; v.ec = ec; v.ea = ea;
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        mpat = 4'b1101;
        mcnt = 0;
    endtask

    task automatic model_step(input bit xb, input bit vb, input bit lb,
                              input logic [PW-1:0] pat, input bit ov,
                              output bit eh, output bit ea);
        logic [PW-1:0] w;
        eh = 1'b0;
        if (lb) begin
            mpat = pat;
            mq.delete();
            mcnt = 0;
        end else if (vb) begin
            if (mq.size() == PW - 1) begin
                w = '0;
                foreach (mq[i]) w = {w[PW-2:0], mq[i]};
                w = {w[PW-2:0], xb};
                eh = (w == mpat);
            end
            mq.push_back(xb);
            if (mq.size() > PW - 1) void'(mq.pop_front());
            if (eh) begin
                if (mcnt < 255) mcnt++;
                if (!ov) mq.delete();
            end
        end
        ea = (mq.size() == PW - 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        x = 1'b0; x_valid = 1'b0; pat_load = 1'b0; pattern = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one cycle and check; z is checked where the build makes it valid.
    task automatic apply(input bit xb, input bit vb, input bit lb, input logic [PW-1:0] pat,
                         input bit ov, input bit eh, input int ec, input bit ea,
                         input string nm);
        x = xb; x_valid = vb; pat_load = lb; pattern = pat; overlap_en = ov;
        #1;
`ifdef SEQ_DET_MEALY_EN
        check({nm, " z_a"}, 32'(z_a), 32'(eh));
        check({nm, " z_b"}, 32'(z_b), 32'(eh));
`endif
        @(posedge clk);
        #1;
`ifndef SEQ_DET_MEALY_EN
        check({nm, " z_a"}, 32'(z_a), 32'(eh));
        check({nm, " z_b"}, 32'(z_b), 32'(eh));
`endif
        check({nm, " cnt_a"}, 32'(cnt_a), 32'(ec));
        check({nm, " cnt_b"}, 32'(cnt_b), 32'(sat3(ec)));
        check({nm, " armed_a"}, 32'(armed_a), 32'(ea));
        check({nm, " armed_b"}, 32'(armed_b), 32'(ea));
    endtask

    initial begin
        bit eh, ea;
        bit ov;

        reset = 1'b1;
        x = 1'b0; x_valid = 1'b0; pat_load = 1'b0; pattern = '0; overlap_en = 1'b1;
        #100;
        check("reset z", 32'(z_a), 32'd0);
        check("reset cnt", 32'(cnt_a), 32'd0);
        check("reset armed", 32'(armed_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Overlapping 1101 on 1,1,0,1,1,0,1: hits on bits 4 and 7
        tbl.push_back(mk(0, 1, 1, 0, 4'h0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 4'h0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 4'h0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 4'h0, 1, 1, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 4'h0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 4'h0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 4'h0, 1, 1, 2, 1));
        // Non-overlapping: only bit 4 hits, armed low for three cycles
        tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 4'h0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 4'h0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 4'h0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 4'h0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 4'h0, 0, 0, 1, 1));
        // Gap of 5 invalid cycles (x held at 1 to show it is ignored)
        tbl.push_back(mk(1, 1, 1, 0, 4'h0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 4'h0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 4'h0, 1, 0, 0, 1));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 1, 0, 0, 4'h0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 4'h0, 1, 1, 1, 1));
        // Load 0110 on a completing bit of 1101: bit dropped, then 0,1,1,0 hits
        tbl.push_back(mk(1, 1, 1, 0, 4'h0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 4'h0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 4'h0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 4'h6, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 4'h0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 4'h0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 4'h0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 4'h0, 1, 1, 1, 1));
        // Load 1111, eight ones overlapping: five hits, 2-bit counter saturates at 3
        tbl.push_back(mk(1, 0, 0, 1, 4'hF, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 4'h0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 4'h0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 4'h0, 1, 0, 0, 1));
        for (int i = 1; i <= 5; i++) tbl.push_back(mk(0, 1, 1, 0, 4'h0, 1, 1, i, 1));

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            apply(tbl[i].xb, tbl[i].vb, tbl[i].lb, tbl[i].pat, tbl[i].ov,
                  tbl[i].eh, tbl[i].ec, tbl[i].ea, $sformatf("vec%0d", i));
        end

        // Asynchronous reset between edges mid-pattern
        do_reset();
        apply(1, 1, 0, 4'h0, 1, 0, 0, 0, "ar1");
        apply(1, 1, 0, 4'h0, 1, 0, 0, 0, "ar2");
        apply(0, 1, 0, 4'h0, 1, 0, 0, 1, "ar3");
        apply(1, 1, 0, 4'h0, 1, 1, 1, 1, "ar4");
        apply(1, 1, 0, 4'h0, 1, 0, 1, 1, "ar5");
        apply(0, 1, 0, 4'h0, 1, 0, 1, 1, "ar6");
        x = 1'b0; x_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async z", 32'(z_a), 32'd0);
        check("async cnt", 32'(cnt_a), 32'd0);
        check("async armed", 32'(armed_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        apply(1, 1, 0, 4'h0, 1, 0, 0, 0, "after_async");

        // Randomized stimulus against the model
        do_reset();
        model_reset();
        ov = 1'b1;
        for (int i = 0; i < 600; i++) begin
            bit xb, vb, lb;
            logic [PW-1:0] pat;
            if (i % 25 == 0) ov = 1'($urandom_range(0, 1));
            xb  = 1'($urandom_range(0, 1));
            vb  = ($urandom_range(0, 9) < 8);
            lb  = ($urandom_range(0, 39) == 0);
            pat = PW'($urandom);
            model_step(xb, vb, lb, pat, ov, eh, ea);
            apply(xb, vb, lb, pat, ov, eh, mcnt, ea, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
